// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit MEM-stage loads/stores onto a 16-bit
// asynchronous SRAM as two half-word phases (low, then high), each held for
// WAIT_CYCLES cycles. ready drops for the whole access so the pipeline freezes.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 3,          // cycles per half-word phase, 1..15
    parameter logic [31:0] BASE_ADDR   = 32'd1024    // byte address of SRAM word 0
) (
    input  logic        clk,
    input  logic        rst,          // synchronous, active-low
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    // Counter value on the final cycle of a phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        op_wr_q,     op_wr_d;       // latched operation: 1 = write
    logic [16:0] widx_q,      widx_d;        // latched SRAM word index
    logic [15:0] wdata_hi_q,  wdata_hi_d;    // upper store half, driven in HIGH
    logic [15:0] rd_lo_q,     rd_lo_d;       // low read half, committed with the high half
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q,    dq_out_d;

    // Only bits [18:2] of the offset matter, and the low 19 bits of a
    // difference depend only on the low 19 bits of its operands.
    logic [18:0] off;
    logic [16:0] widx_in;
    logic        phase_end;

    assign off       = address[18:0] - BASE_ADDR[18:0];
    assign widx_in   = off[18:2];
    assign phase_end = (cnt_q == LAST_CNT);

    // Next-state, datapath updates and the combinational ready flag.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        widx_d      = widx_q;
        wdata_hi_d  = wdata_hi_q;
        rd_lo_d     = rd_lo_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        ready       = 1'b1;

        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    // Freeze the pipeline in the same cycle the request shows up.
                    ready       = 1'b0;
                    state_d     = LOW;
                    cnt_d       = 4'd0;
                    op_wr_d     = wr_en;            // write wins over a simultaneous read
                    widx_d      = widx_in;
                    wdata_hi_d  = write_data[31:16];
                    sram_addr_d = {widx_in, 1'b0};
                    dq_out_d    = write_data[15:0];
                end
            end
            LOW: begin
                ready = 1'b0;
                if (phase_end) begin
                    state_d     = HIGH;
                    cnt_d       = 4'd0;
                    sram_addr_d = {widx_q, 1'b1};
                    dq_out_d    = wdata_hi_q;
                    if (!op_wr_q) begin
                        rd_lo_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                ready = 1'b0;
                if (phase_end) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!op_wr_q) begin
                        read_data_d = {sram_dq_in, rd_lo_q};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Never relaunch here: the pipeline advances on this edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            widx_q      <= '0;
            wdata_hi_q  <= '0;
            rd_lo_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            widx_q      <= widx_d;
            wdata_hi_q  <= wdata_hi_d;
            rd_lo_q     <= rd_lo_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // The bus is driven and written only while a write is in LOW or HIGH.
    assign sram_dq_oe  = op_wr_q && ((state_q == LOW) || (state_q == HIGH));
    assign sram_we_n   = ~sram_dq_oe;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign read_data   = read_data_q;

endmodule
